// File: rtl/inertial_integrator_pkg.sv
// Shared types and constants for the inertial integrator slice.
package inertial_pkg;

    typedef enum logic {
        CAL = 1'b0,
        RUN = 1'b1
    } state_t;

    localparam int PTCH_FRAC_SHIFT = 11;
    localparam int ACC_SHIFT       = 13;
    localparam int INT_W           = 27;

    localparam logic signed [15:0] AZ_OFFSET_DEF     = 16'sh00A0;
    localparam logic signed [15:0] PTCH_ACC_GAIN_DEF = 16'sd327;

endpackage

// File: rtl/inertial_integrator_cal.sv
// Gyro offset calibration: averages 2^CAL_LOG2 raw rate samples into offset.
// done is high combinationally in the cycle of the final sample; offset loads on that edge.
module gyro_offset_cal #(
    parameter int CAL_LOG2 = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        smp_vld,
    input  logic [15:0] raw,
    output logic [15:0] offset,
    output logic        done
);
    localparam int ACC_W = 16 + CAL_LOG2;

    logic [CAL_LOG2-1:0]     cal_cnt;
    logic signed [ACC_W-1:0] cal_acc;
    logic signed [ACC_W-1:0] acc_nxt;
    logic signed [ACC_W-1:0] acc_avg;

    assign acc_nxt = cal_acc + {{CAL_LOG2{raw[15]}}, raw};
    assign acc_avg = acc_nxt >>> CAL_LOG2;
    assign done    = smp_vld && (cal_cnt == '1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cal_cnt <= '0;
            cal_acc <= '0;
            offset  <= '0;
        end else if (clr) begin
            cal_cnt <= '0;
            cal_acc <= '0;
        end else if (smp_vld) begin
            if (done) begin
                offset  <= acc_avg[15:0];
                cal_cnt <= '0;
                cal_acc <= '0;
            end else begin
                cal_cnt <= cal_cnt + 1'b1;
                cal_acc <= acc_nxt;
            end
        end
    end

endmodule

// File: rtl/inertial_integrator.sv
// Gyro-rate to pitch integrator with offset calibration.
// Optional accel drift correction enabled by defining INERTIAL_FUSION_EN.
module inertial_integrator
    import inertial_pkg::*;
#(
    parameter int                CAL_LOG2      = 4,
    parameter logic signed [15:0] AZ_OFFSET     = AZ_OFFSET_DEF,
    parameter logic signed [15:0] PTCH_ACC_GAIN = PTCH_ACC_GAIN_DEF,
    parameter logic signed [26:0] FUSION_STEP   = 27'sd1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vld_in,
    input  logic [15:0] ptch_rt_raw,
    input  logic [15:0] AZ,
    input  logic        cal_req,
    output logic [15:0] ptch,
    output logic [15:0] ptch_rt,
    output logic        vld,
    output logic        cal_done
);
    localparam logic signed [INT_W-1:0] INT_MAX = {1'b0, {(INT_W-1){1'b1}}};
    localparam logic signed [INT_W-1:0] INT_MIN = {1'b1, {(INT_W-1){1'b0}}};

    state_t state, state_nxt;

    logic        cal_smp;
    logic        run_smp;
    logic        cal_fin;
    logic [15:0] offset;

    assign cal_smp  = vld_in && !cal_req && (state == CAL);
    assign run_smp  = vld_in && !cal_req && (state == RUN);
    assign cal_done = (state == RUN);

    gyro_offset_cal #(.CAL_LOG2(CAL_LOG2)) u_cal (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (cal_req),
        .smp_vld (cal_smp),
        .raw     (ptch_rt_raw),
        .offset  (offset),
        .done    (cal_fin)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= CAL;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CAL: if (cal_fin) state_nxt = RUN;
            RUN: if (cal_req) state_nxt = CAL;
            default: state_nxt = CAL;
        endcase
    end

    logic signed [15:0]      rt_new;
    logic signed [INT_W-1:0] fusion_adj;
    logic signed [INT_W-1:0] ptch_int;
    logic signed [INT_W:0]   int_sum;
    logic signed [INT_W-1:0] int_sat;

    assign rt_new = ptch_rt_raw - offset;

`ifdef INERTIAL_FUSION_EN
    logic signed [15:0] az_comp;
    logic signed [31:0] az_ext;
    logic signed [31:0] gain_ext;
    logic signed [31:0] prod;
    logic signed [15:0] ptch_acc;

    assign az_comp    = AZ - AZ_OFFSET;
    assign az_ext     = {{16{az_comp[15]}}, az_comp};
    assign gain_ext   = {{16{PTCH_ACC_GAIN[15]}}, PTCH_ACC_GAIN};
    assign prod       = az_ext * gain_ext;
    assign ptch_acc   = 16'(prod >>> ACC_SHIFT);
    // Compared against the registered pitch, i.e. the value the PID currently sees.
    assign fusion_adj = (ptch_acc > $signed(ptch)) ? FUSION_STEP : -FUSION_STEP;
`else
    logic unused_fusion;
    assign unused_fusion = ^{AZ, AZ_OFFSET, PTCH_ACC_GAIN, FUSION_STEP};
    assign fusion_adj    = '0;
`endif

    assign int_sum = {ptch_int[INT_W-1], ptch_int}
                   - {{(INT_W-15){rt_new[15]}}, rt_new}
                   + {fusion_adj[INT_W-1], fusion_adj};

    // Overflow shows up as disagreement between the two top bits of the 28-bit sum.
    always_comb begin
        int_sat = int_sum[INT_W-1:0];
        if (int_sum[INT_W] != int_sum[INT_W-1])
            int_sat = int_sum[INT_W] ? INT_MIN : INT_MAX;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptch_int <= '0;
            ptch     <= '0;
            ptch_rt  <= '0;
            vld      <= 1'b0;
        end else begin
            vld <= 1'b0;
            if (state == RUN && cal_req) begin
                ptch_int <= '0;
                ptch     <= '0;
                ptch_rt  <= '0;
            end else if (run_smp) begin
                ptch_rt  <= rt_new;
                ptch_int <= int_sat;
                ptch     <= int_sat[PTCH_FRAC_SHIFT +: 16];
                vld      <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_inertial_integrator.sv
// Self-checking bench for inertial_integrator against an arithmetic reference model.
module tb_inertial_integrator;

`ifdef INERTIAL_FUSION_EN
    localparam bit FUS = 1'b1;
`else
    localparam bit FUS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vld_in;
    logic [15:0] ptch_rt_raw;
    logic [15:0] AZ;
    logic        cal_req;
    logic [15:0] ptch;
    logic [15:0] ptch_rt;
    logic        vld;
    logic        cal_done;

    always #5 clk = ~clk;

    inertial_integrator dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .vld_in      (vld_in),
        .ptch_rt_raw (ptch_rt_raw),
        .AZ          (AZ),
        .cal_req     (cal_req),
        .ptch        (ptch),
        .ptch_rt     (ptch_rt),
        .vld         (vld),
        .cal_done    (cal_done)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit     m_run;
    int     m_n;
    int     m_sum;
    int     m_off;
    int     m_rt;
    int     m_ptch;
    longint m_int;
    bit     m_vld;

    function automatic int s16(input int x);
        logic [15:0] t;
        t = x[15:0];
        return int'($signed(t));
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_n = 0; m_sum = 0; m_off = 0;
        m_rt = 0; m_ptch = 0; m_int = 0; m_vld = 0;
    endtask

    task automatic model_step(input bit v, input bit cr, input int raw, input int az);
        int acc;
        int adj;
        m_vld = 0;
        if (!m_run) begin
            if (cr) begin
                m_n = 0; m_sum = 0;
            end else if (v) begin
                m_sum += s16(raw);
                m_n++;
                if (m_n == 16) begin
                    m_off = m_sum >>> 4;
                    m_run = 1; m_n = 0; m_sum = 0;
                end
            end
        end else if (cr) begin
            m_run = 0; m_int = 0; m_ptch = 0; m_rt = 0; m_n = 0; m_sum = 0;
        end else if (v) begin
            m_rt = s16(raw - m_off);
            adj = 0;
            if (FUS) begin
                acc = s16((s16(az - 160) * 327) >>> 13);
                adj = (acc > m_ptch) ? 1024 : -1024;
            end
            m_int = m_int - m_rt + adj;
            if (m_int > 64'sd67108863)  m_int = 64'sd67108863;
            if (m_int < -64'sd67108864) m_int = -64'sd67108864;
            m_ptch = int'(m_int >>> 11);
            m_vld = 1;
        end
    endtask

    task automatic compare_all();
        check("vld", {15'd0, vld}, {15'd0, m_vld});
        check("cal_done", {15'd0, cal_done}, {15'd0, m_run});
        check("ptch", ptch, m_ptch[15:0]);
        check("ptch_rt", ptch_rt, m_rt[15:0]);
    endtask

    task automatic step(input bit v, input bit cr, input logic [15:0] raw, input logic [15:0] az);
        @(negedge clk);
        vld_in = v; cal_req = cr; ptch_rt_raw = raw; AZ = az;
        @(posedge clk);
        model_step(v, cr, int'(raw), int'(az));
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; vld_in = 1'b1; cal_req = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        compare_all();
        @(negedge clk);
        rst_n = 1'b1; vld_in = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; vld_in = 1'b0; cal_req = 1'b0; ptch_rt_raw = '0; AZ = '0;
        model_reset();
        do_reset();

        // Calibration with raw 0x0040, spaced by idle cycles
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 16'h0040, 16'h0000);
            if (i % 4 == 0) step(1'b0, 1'b0, 16'h0000, 16'h0000);
        end

        // Zero rate, back-to-back strobes
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'h0040, 16'h0000);
        check("zero_rate_rt", ptch_rt, 16'h0000);
        step(1'b0, 1'b0, 16'h0040, 16'h0000);

        // Constant rate
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 16'h0840, 16'h00A0);
        check("const_rt", ptch_rt, 16'h0800);
`ifndef INERTIAL_FUSION_EN
        check("const_ptch", ptch, 16'hFFF0);
`endif

        // Randomized traffic including occasional recalibration requests
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0),
                 16'($urandom), 16'($urandom));

        // Recalibration: force a known RUN state first
        step(1'b0, 1'b1, 16'h0000, 16'h0000);
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 16'h0040, 16'h0000);
        step(1'b1, 1'b0, 16'h0100, 16'h0000);
        step(1'b1, 1'b1, 16'h0100, 16'h0000);
        check("recal_vld", {15'd0, vld}, 16'h0000);
        check("recal_done", {15'd0, cal_done}, 16'h0000);
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 16'hFFF0, 16'h0000);
        step(1'b1, 1'b0, 16'hFFF0, 16'h0000);
        check("recal_off_a", ptch_rt, 16'h0000);
        step(1'b1, 1'b0, 16'h0000, 16'h0000);
        check("recal_off_b", ptch_rt, 16'h0010);

        // Saturation: ptch_rt = -32768 every sample
        for (int i = 0; i < 2200; i++) step(1'b1, 1'b0, 16'h7FF0, 16'h0000);
        check("sat_rt", ptch_rt, 16'h8000);
        check("sat_ptch", ptch, 16'h7FFF);

`ifdef INERTIAL_FUSION_EN
        // Fusion convergence toward accel pitch of 100
        step(1'b0, 1'b1, 16'h0000, 16'h0000);
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 16'h0000, 16'h0000);
        for (int i = 0; i < 300; i++) step(1'b1, 1'b0, 16'h0000, 16'h0A6A);
        check("fusion_ptch", 16'(ptch == 16'd99 || ptch == 16'd100), 16'h0001);
`endif

        // Reset mid-run loses everything
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h1234, 16'h0000);
        do_reset();
        step(1'b1, 1'b0, 16'h0040, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
